ftdi_tx_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing the single TX AXI-stream port of ftdi_245fifo_top

---
 rtl/ftdi_tx_arbiter_pkg.sv | 25 ++
 rtl/ftdi_tx_arbiter_skid.sv | 120 ++++++++++++
 rtl/ftdi_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ftdi_tx_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftdi_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter_pkg
//   Shared types and width helpers for the FTDI TX arbitration path.
//   - arb_state_e   : packet arbiter state (IDLE = searching, BUSY = locked)
//   - axis_data_w() : AXI-stream data width in bits for a width exponent EW
//   - axis_keep_w() : matching tkeep width (one bit per byte)
// ---------------------------------------------------------------------------
package ftdi_tx_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // W = 8 << EW bits
  function automatic int axis_data_w(input int ew);
    return 8 << ew;
  endfunction

  // K = 1 << EW keep bits
  function automatic int axis_keep_w(input int ew);
    return 1 << ew;
  endfunction

endpackage

// File: rtl/ftdi_tx_arbiter_skid.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
//   Two-entry AXI-stream register slice. Entry 0 drives the output port
//   directly; entry 1 catches the one beat that can arrive in the cycle the
//   downstream stalls. Because i_tready depends only on entry 1 being empty,
//   the ready path is fully registered on both sides, and with o_tready held
//   high the slice sustains one beat per cycle.
//
// Ports
//   clk, rst_async            : clock, asynchronous active-high reset
//   i_tvalid/i_tready         : upstream handshake
//   i_tdata/i_tkeep/i_tlast   : upstream beat (W data bits, K keep bits)
//   o_tvalid/o_tready         : downstream handshake
//   o_tdata/o_tkeep/o_tlast   : downstream beat, stable while stalled
// ---------------------------------------------------------------------------
module axis_skid_buffer
  import ftdi_tx_arbiter_pkg::*;
#(
  parameter  int EW = 2,
  localparam int W  = axis_data_w(EW),
  localparam int K  = axis_keep_w(EW)
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic         i_tvalid,
  output logic         i_tready,
  input  logic [W-1:0] i_tdata,
  input  logic [K-1:0] i_tkeep,
  input  logic         i_tlast,
  input  logic         o_tready,
  output logic         o_tvalid,
  output logic [W-1:0] o_tdata,
  output logic [K-1:0] o_tkeep,
  output logic         o_tlast
);

  // entry 0: output register
  logic         out_vld_q,  out_vld_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [K-1:0] out_keep_q, out_keep_d;
  logic         out_last_q, out_last_d;

  // entry 1: skid register
  logic         sk_full_q,  sk_full_d;
  logic [W-1:0] sk_data_q,  sk_data_d;
  logic [K-1:0] sk_keep_q,  sk_keep_d;
  logic         sk_last_q,  sk_last_d;

  logic in_fire;
  logic out_free;

  assign i_tready = !sk_full_q;
  assign in_fire  = i_tvalid && !sk_full_q;
  // entry 0 can take a new beat when empty or being drained this cycle
  assign out_free = !out_vld_q || o_tready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_keep_d = out_keep_q;
    out_last_d = out_last_q;
    sk_full_d  = sk_full_q;
    sk_data_d  = sk_data_q;
    sk_keep_d  = sk_keep_q;
    sk_last_d  = sk_last_q;

    if (out_free) begin
      if (sk_full_q) begin
        // Skid beat is older than anything upstream; it moves forward first.
        // i_tready is low in this cycle, so no new beat can arrive.
        out_vld_d  = 1'b1;
        out_data_d = sk_data_q;
        out_keep_d = sk_keep_q;
        out_last_d = sk_last_q;
        sk_full_d  = 1'b0;
      end else begin
        out_vld_d = in_fire;
        if (in_fire) begin
          out_data_d = i_tdata;
          out_keep_d = i_tkeep;
          out_last_d = i_tlast;
        end
      end
    end else if (in_fire) begin
      // Output is stalled: park the incoming beat in the skid entry.
      sk_full_d = 1'b1;
      sk_data_d = i_tdata;
      sk_keep_d = i_tkeep;
      sk_last_d = i_tlast;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
      sk_full_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_keep_q  <= '0;
      sk_last_q  <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_keep_q <= out_keep_d;
      out_last_q <= out_last_d;
      sk_full_q  <= sk_full_d;
      sk_data_q  <= sk_data_d;
      sk_keep_q  <= sk_keep_d;
      sk_last_q  <= sk_last_d;
    end
  end

  assign o_tvalid = out_vld_q;
  assign o_tdata  = out_data_q;
  assign o_tkeep  = out_keep_q;
  assign o_tlast  = out_last_q;

endmodule

// File: rtl/ftdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ftdi_tx_arbiter
//   Packet-level round-robin arbiter that shares the single TX AXI-stream
//   port of ftdi_245fifo_top between N requesters. One requester is locked
//   per packet; the lock is released on the edge that accepts its tlast
//   beat, after which one IDLE cycle re-arbitrates starting just past the
//   requester that was last served. The output goes through a 2-entry skid
//   buffer so back-to-back beats inside a packet keep full throughput.
//
// Ports
//   clk, rst_async            : user clock, asynchronous active-high reset
//   i_tvalid[N]/i_tready[N]   : per-requester handshake (only granted ready)
//   i_tdata[N*W], i_tkeep[N*K], i_tlast[N] : requester r at [r*W +: W] etc.
//   o_tready/o_tvalid         : to/from ftdi_245fifo_top tx_* handshake
//   o_tdata/o_tkeep/o_tlast   : merged output stream
//   grant_valid               : a requester is locked
//   grant_idx[CW]             : index of the locked requester
// ---------------------------------------------------------------------------
module ftdi_tx_arbiter
  import ftdi_tx_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int EW = 2,
  localparam int W  = axis_data_w(EW),
  localparam int K  = axis_keep_w(EW),
  localparam int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_async,
  input  logic [N-1:0]   i_tvalid,
  output logic [N-1:0]   i_tready,
  input  logic [N*W-1:0] i_tdata,
  input  logic [N*K-1:0] i_tkeep,
  input  logic [N-1:0]   i_tlast,
  input  logic           o_tready,
  output logic           o_tvalid,
  output logic [W-1:0]   o_tdata,
  output logic [K-1:0]   o_tkeep,
  output logic           o_tlast,
  output logic           grant_valid,
  output logic [CW-1:0]  grant_idx
);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] gnt_q,   gnt_d;
  logic [CW-1:0] last_q,  last_d;

  logic          req_found;
  logic [CW-1:0] req_pick;

  logic          g_valid;
  logic [W-1:0]  g_data;
  logic [K-1:0]  g_keep;
  logic          g_last;

  logic          busy;
  logic          sk_in_ready;
  logic          accept;

  // Requester visited at offset 'off' of the rotating scan that starts
  // one past 'base' and wraps modulo N.
  function automatic logic [CW-1:0] rr_slot(input logic [CW-1:0] base, input int off);
    int s;
    s = (int'(base) + 1 + off) % N;
    return CW'(s);
  endfunction

  // Rotating-priority search: first valid requester after last_q.
  always_comb begin
    req_found = 1'b0;
    req_pick  = '0;
    for (int i = 0; i < N; i++) begin
      if (!req_found && i_tvalid[rr_slot(last_q, i)]) begin
        req_found = 1'b1;
        req_pick  = rr_slot(last_q, i);
      end
    end
  end

  // Grant mux: select the locked requester's beat.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_keep  = '0;
    g_last  = 1'b0;
    for (int r = 0; r < N; r++) begin
      if (gnt_q == CW'(r)) begin
        g_valid = i_tvalid[r];
        g_data  = i_tdata[r*W +: W];
        g_keep  = i_tkeep[r*K +: K];
        g_last  = i_tlast[r];
      end
    end
  end

  assign busy   = (state_q == ARB_BUSY);
  assign accept = busy && g_valid && sk_in_ready;

  // Ready goes back only to the locked requester; nothing is ready in IDLE.
  always_comb begin
    i_tready = '0;
    for (int r = 0; r < N; r++) begin
      i_tready[r] = busy && (gnt_q == CW'(r)) && sk_in_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (req_found) begin
          state_d = ARB_BUSY;
          gnt_d   = req_pick;
        end
      end
      ARB_BUSY: begin
        // A requester that drops valid mid-packet keeps the lock: the
        // release happens only on an accepted tlast beat.
        if (accept && g_last) begin
          state_d = ARB_IDLE;
          last_d  = gnt_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      // last = N-1 so requester 0 wins the first search after reset
      last_q  <= CW'(N - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  assign grant_valid = busy;
  assign grant_idx   = gnt_q;

  // Output register slice; beats of a following packet queue behind any
  // beats of the previous one still held here, so packets never interleave.
  axis_skid_buffer #(
    .EW (EW)
  ) u_skid (
    .clk       (clk),
    .rst_async (rst_async),
    .i_tvalid  (busy && g_valid),
    .i_tready  (sk_in_ready),
    .i_tdata   (g_data),
    .i_tkeep   (g_keep),
    .i_tlast   (g_last),
    .o_tready  (o_tready),
    .o_tvalid  (o_tvalid),
    .o_tdata   (o_tdata),
    .o_tkeep   (o_tkeep),
    .o_tlast   (o_tlast)
  );

endmodule

// File: tb/tb_ftdi_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ftdi_tx_arbiter
//   Scoreboard bench. Requester packets are queued per requester; a
//   packet-level round-robin model turns them into the expected output beat
//   stream and expected grant order. A driver process plays the requesters
//   and the downstream ready; a monitor process checks every output beat,
//   grant, ready legality and output stability under backpressure.
// ---------------------------------------------------------------------------
module tb_ftdi_tx_arbiter;

  localparam int N  = 4;
  localparam int EW = 2;
  localparam int W  = 32;
  localparam int K  = 4;
  localparam int CW = 2;

  typedef struct {
    logic [W-1:0] data;
    logic [K-1:0] keep;
    logic         last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_async;
  logic [N-1:0]   i_tvalid;
  logic [N-1:0]   i_tready;
  logic [N*W-1:0] i_tdata;
  logic [N*K-1:0] i_tkeep;
  logic [N-1:0]   i_tlast;
  logic           o_tready;
  logic           o_tvalid;
  logic [W-1:0]   o_tdata;
  logic [K-1:0]   o_tkeep;
  logic           o_tlast;
  logic           grant_valid;
  logic [CW-1:0]  grant_idx;

  always #5 clk = ~clk;

  ftdi_tx_arbiter #(.N(N), .EW(EW)) dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .i_tvalid    (i_tvalid),
    .i_tready    (i_tready),
    .i_tdata     (i_tdata),
    .i_tkeep     (i_tkeep),
    .i_tlast     (i_tlast),
    .o_tready    (o_tready),
    .o_tvalid    (o_tvalid),
    .o_tdata     (o_tdata),
    .o_tkeep     (o_tkeep),
    .o_tlast     (o_tlast),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  beat_t rq[N][$];     // beats still to be offered by each requester
  beat_t mq[N][$];     // model copy, consumed by the round-robin model
  beat_t exp_q[$];     // expected output beats in order
  int    exp_g[$];     // expected grant order
  int    m_last = N - 1;

  int checks = 0;
  int errors = 0;

  int gap_cnt[N];
  int acc[N];
  int gap_req = -1;
  int gap_at  = 0;
  int gap_len = 0;
  bit rand_gap = 1'b0;
  int ordy_mode = 1;   // 0: ready low, 1: ready high, 2: random

  bit bubble_en = 1'b0;
  int last_beat_cyc = -1;
  bit prev_beat_last = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_beat(input int r, input logic [W-1:0] d, input logic [K-1:0] k, input logic l);
    beat_t b;
    b.data = d;
    b.keep = k;
    b.last = l;
    rq[r].push_back(b);
    mq[r].push_back(b);
  endtask

  task automatic add_pkt(input int r, input int len, input logic [W-1:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      if (rnd) add_beat(r, W'($urandom), K'($urandom_range(0, 15)), (i == len - 1));
      else     add_beat(r, base + W'(i), 4'hF, (i == len - 1));
    end
  endtask

  // Packet-level round robin: next requester with a pending packet after
  // the last one served sends its whole packet.
  task automatic run_model();
    int r;
    bit any;
    beat_t b;
    forever begin
      any = 1'b0;
      r = 0;
      for (int i = 1; i <= N; i++) begin
        if (!any && mq[(m_last + i) % N].size() > 0) begin
          any = 1'b1;
          r = (m_last + i) % N;
        end
      end
      if (!any) break;
      exp_g.push_back(r);
      b.last = 1'b0;
      while (!b.last && mq[r].size() > 0) begin
        b = mq[r].pop_front();
        exp_q.push_back(b);
      end
      m_last = r;
    end
  endtask

  function automatic bit all_empty();
    bit e;
    e = (exp_q.size() == 0) && (exp_g.size() == 0);
    for (int r = 0; r < N; r++) if (rq[r].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!all_empty()) begin
      errors++;
      $display("FAIL %s_timeout actual_pending=%0d required=0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Driver: requesters and downstream ready, updated 1 time unit after clk.
  initial begin : driver
    logic [N-1:0] hs;
    beat_t b;
    i_tvalid = '0;
    i_tdata  = '0;
    i_tkeep  = '0;
    i_tlast  = '0;
    o_tready = 1'b1;
    for (int r = 0; r < N; r++) begin
      gap_cnt[r] = 0;
      acc[r]     = 0;
    end
    forever begin
      @(negedge clk);
      hs = i_tvalid & i_tready;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (hs[r] && rq[r].size() > 0) begin
          b = rq[r].pop_front();
          if (b.last) acc[r] = 0;
          else begin
            acc[r]++;
            if (r == gap_req && acc[r] == gap_at) gap_cnt[r] = gap_len;
            else if (rand_gap && $urandom_range(0, 3) == 0) gap_cnt[r] = $urandom_range(1, 3);
          end
        end else if (gap_cnt[r] > 0) begin
          gap_cnt[r]--;
        end
      end
      case (ordy_mode)
        0:       o_tready = 1'b0;
        1:       o_tready = 1'b1;
        default: o_tready = 1'($urandom_range(0, 1));
      endcase
      for (int r = 0; r < N; r++) begin
        if (rq[r].size() > 0) begin
          i_tvalid[r]         = (gap_cnt[r] == 0);
          i_tdata[r*W +: W]   = rq[r][0].data;
          i_tkeep[r*K +: K]   = rq[r][0].keep;
          i_tlast[r]          = rq[r][0].last;
        end else begin
          i_tvalid[r]         = 1'b0;
          i_tdata[r*W +: W]   = '0;
          i_tkeep[r*K +: K]   = '0;
          i_tlast[r]          = 1'b0;
        end
      end
    end
  end

  // Monitor: samples on the falling edge.
  initial begin : monitor
    bit           pstall;
    bit           pgv;
    logic [W-1:0] pd;
    logic [K-1:0] pk;
    logic         pl;
    logic [N-1:0] allowed;
    beat_t        b;
    int           g;
    pstall = 1'b0;
    pgv    = 1'b0;
    pd     = '0;
    pk     = '0;
    pl     = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_async) begin
        pstall = 1'b0;
        pgv    = 1'b0;
        continue;
      end
      if (pstall)
        check("stall_hold", {o_tvalid, o_tlast, o_tkeep, o_tdata}, {1'b1, pl, pk, pd});
      if (o_tvalid && o_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_extra actual=%0h required=none", o_tdata);
        end else begin
          b = exp_q.pop_front();
          check("out_beat", {o_tlast, o_tkeep, o_tdata}, {b.last, b.keep, b.data});
          if (bubble_en) begin
            if (last_beat_cyc >= 0)
              check("beat_spacing", 64'(cyc - last_beat_cyc), prev_beat_last ? 64'd2 : 64'd1);
            last_beat_cyc  = cyc;
            prev_beat_last = b.last;
          end
        end
      end
      allowed = grant_valid ? (N'(1) << grant_idx) : '0;
      check("tready_legal", 64'(i_tready & ~allowed), 64'd0);
      if (grant_valid && !pgv) begin
        if (exp_g.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_extra actual=%0d required=none", grant_idx);
        end else begin
          g = exp_g.pop_front();
          check("grant_order", 64'(grant_idx), 64'(g));
        end
      end
      pgv    = grant_valid;
      pstall = o_tvalid && !o_tready;
      pd     = o_tdata;
      pk     = o_tkeep;
      pl     = o_tlast;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    rst_async = 1'b1;
    #1;
    // reset values
    check("rst_outputs", {o_tvalid, o_tlast, o_tkeep, o_tdata},   64'd0);
    check("rst_grant",   {grant_valid, grant_idx, i_tready},       64'd0);
    repeat (3) @(negedge clk);
    rst_async = 1'b0;

    // T1: all idle for 20 cycles
    repeat (20) begin
      @(negedge clk);
      check("idle_quiet", {o_tvalid, grant_valid, i_tready}, 64'd0);
    end

    // T3: all four requesters, 2-beat packets tagged by index; r0 has two
    bubble_en = 1'b1;
    last_beat_cyc = -1;
    for (int r = 0; r < N; r++) add_pkt(r, 2, 32'hC000_0000 | (r << 8), 1'b0);
    add_pkt(0, 2, 32'hC000_1000, 1'b0);
    run_model();
    wait_done(200, "t3_rr");
    bubble_en = 1'b0;

    // T4: 16-beat packet from r1 under random backpressure
    ordy_mode = 2;
    add_pkt(1, 16, 32'hA100_0000, 1'b0);
    run_model();
    wait_done(400, "t4_bp");
    ordy_mode = 1;

    // T2: r2 alone sends 3 words
    @(negedge clk);
    bubble_en = 1'b1;
    last_beat_cyc = -1;
    add_beat(2, 32'h1111_1111, 4'hF, 1'b0);
    add_beat(2, 32'h2222_2222, 4'hF, 1'b0);
    add_beat(2, 32'h3333_3333, 4'hF, 1'b1);
    run_model();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_tvalid[2] && n < 20);
    check("t2_no_grant_yet", 64'(grant_valid), 64'd0);
    @(negedge clk);
    check("t2_grant", {grant_valid, grant_idx}, {1'b1, 2'd2});
    wait_done(100, "t2_single");
    bubble_en = 1'b0;
    check("t2_back_idle", 64'(grant_valid), 64'd0);

    // T5: r3 stalls 5 cycles mid-packet while r0 waits
    gap_req = 3;
    gap_at  = 2;
    gap_len = 5;
    add_pkt(3, 6, 32'h3300_0000, 1'b0);
    add_pkt(0, 2, 32'h0000_5500, 1'b0);
    run_model();
    wait_done(200, "t5_stall");
    gap_req = -1;

    // Random traffic with gaps and backpressure
    rand_gap  = 1'b1;
    ordy_mode = 2;
    repeat (4) begin
      for (int r = 0; r < N; r++)
        repeat ($urandom_range(0, 2)) add_pkt(r, $urandom_range(1, 5), '0, 1'b1);
      run_model();
      wait_done(2000, "rand");
    end
    rand_gap  = 1'b0;

    // T6: reset mid-packet from r1 with the output stalled
    ordy_mode = 0;
    add_pkt(1, 8, 32'h6100_0000, 1'b0);
    run_model();
    repeat (6) @(posedge clk);
    #3;
    rst_async = 1'b1;
    #1;
    check("t6_rst_immediate", {o_tvalid, grant_valid, i_tready}, 64'd0);
    for (int r = 0; r < N; r++) begin
      rq[r].delete();
      mq[r].delete();
      acc[r]     = 0;
      gap_cnt[r] = 0;
    end
    exp_q.delete();
    exp_g.delete();
    m_last = N - 1;
    ordy_mode = 1;
    repeat (2) @(negedge clk);
    rst_async = 1'b0;
    @(negedge clk);
    check("t6_after_rst", {o_tvalid, grant_valid}, 64'd0);
    add_pkt(1, 2, 32'h6200_0000, 1'b0);
    add_pkt(0, 2, 32'h6000_0000, 1'b0);
    run_model();
    wait_done(200, "t6_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
